// File: rtl/demux116_if.sv
// Bus bundle for the 1-to-16 demultiplexer: one input stream, sixteen output lanes,
// plus the sweep pointer and accepted-word counter for observation.
interface demux116_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0]    in_data;
    logic [3:0]          in_sel;
    logic                in_valid;
    logic                in_ready;
    logic                mode;
    logic [16*WIDTH-1:0] out_data;
    logic [15:0]         out_valid;
    logic [15:0]         out_ready;
    logic [3:0]          ptr;
    logic [15:0]         count;

    modport master (
        output in_data, in_sel, in_valid, mode, out_ready,
        input  in_ready, out_data, out_valid, ptr, count
    );

    modport slave (
        input  in_data, in_sel, in_valid, mode, out_ready,
        output in_ready, out_data, out_valid, ptr, count
    );
endinterface

// File: rtl/demux116.sv
// Routes one input word per cycle into one of sixteen 1-deep lane registers,
// chosen either by in_sel or by an internal round-robin pointer.
module demux116 #(
    parameter int WIDTH    = 1,
    parameter bit SWEEP_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    demux116_if.slave  bus
);
    // Handshake: a word moves on any edge where valid & ready were both high
    // beforehand; ready never depends on valid, and a stalled source holds its word.
    logic [15:0][WIDTH-1:0] lane_data_q;
    logic [15:0]            lane_valid_q;
    logic [3:0]             ptr_q;
    logic [15:0]            count_q;

    logic       eff_mode;
    logic [3:0] dst;
    logic       ready;
    logic       accept;

    always_comb begin
        eff_mode = SWEEP_EN && bus.mode;
        dst      = eff_mode ? ptr_q : bus.in_sel;
        // A full lane still accepts if it is being drained this cycle.
        ready    = ~lane_valid_q[dst] | bus.out_ready[dst];
        accept   = bus.in_valid & ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_data_q  <= '0;
            lane_valid_q <= '0;
            ptr_q        <= '0;
            count_q      <= '0;
        end else begin
            for (int k = 0; k < 16; k++) begin
                if (accept && (dst == 4'(k))) begin
                    lane_data_q[k]  <= bus.in_data;
                    lane_valid_q[k] <= 1'b1;
                end else if (lane_valid_q[k] && bus.out_ready[k]) begin
                    lane_valid_q[k] <= 1'b0;
                end
            end
            if (accept) begin
                count_q <= count_q + 16'd1;
                if (eff_mode) begin
                    ptr_q <= ptr_q + 4'd1;
                end
            end
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_data  = lane_data_q;
    assign bus.out_valid = lane_valid_q;
    assign bus.ptr       = ptr_q;
    assign bus.count     = count_q;
endmodule

// File: tb/tb_demux116.sv
// Randomized and directed bench for demux116 against a lane-array reference model
// with a delivery scoreboard.
module tb_demux116;
    localparam int W = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    demux116_if #(.WIDTH(W)) bus();
    demux116 #(.WIDTH(W), .SWEEP_EN(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] m_data[16];
    bit           m_valid[16];
    int           m_ptr;
    int           m_count;
    logic [7:0]   exp_q[$];
    logic         last_rdy;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 16; k++) begin
            m_data[k]  = '0;
            m_valid[k] = 1'b0;
        end
        m_ptr   = 0;
        m_count = 0;
        exp_q.delete();
    endtask

    task automatic apply_reset();
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_sel    = '0;
        bus.in_data   = '0;
        bus.mode      = 1'b0;
        bus.out_ready = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_ptr", 32'(bus.ptr), 0);
        check("rst_count", 32'(bus.count), 0);
        check("rst_out_data_zero", 32'(bus.out_data != '0), 0);
        rst_n = 1'b1;
        model_reset();
    endtask

    // Called one unit after a rising edge; returns one unit after the next rising edge.
    task automatic step(input bit v, input logic [3:0] sel, input logic [W-1:0] d,
                        input bit md, input logic [15:0] ordy);
        int          dst;
        bit          rdy;
        bit          acc;
        logic [15:0] mv_vec;
        int          n_exp;
        int          n_obs;
        bus.in_valid  = v;
        bus.in_sel    = sel;
        bus.in_data   = d;
        bus.mode      = md;
        bus.out_ready = ordy;
        #3;
        dst = md ? m_ptr : int'(sel);
        rdy = !m_valid[dst] || ordy[dst];
        acc = v && rdy;
        last_rdy = bus.in_ready;
        check("in_ready", 32'(bus.in_ready), 32'(rdy));
        for (int k = 0; k < 16; k++) mv_vec[k] = m_valid[k];
        check("out_valid", 32'(bus.out_valid), 32'(mv_vec));
        check("ptr", 32'(bus.ptr), 32'(m_ptr));
        check("count", 32'(bus.count), 32'(m_count));
        for (int k = 0; k < 16; k++)
            if (m_valid[k]) check("lane_data", 32'(bus.out_data[k*W +: W]), 32'(m_data[k]));
        for (int k = 0; k < 16; k++)
            if (m_valid[k] && ordy[k]) exp_q.push_back({4'(k), m_data[k]});
        n_exp = exp_q.size();
        n_obs = 0;
        for (int k = 0; k < 16; k++) begin
            if (bus.out_valid[k] && ordy[k]) begin
                n_obs++;
                if (exp_q.size() > 0)
                    check("delivery", 32'({4'(k), bus.out_data[k*W +: W]}), 32'(exp_q.pop_front()));
            end
        end
        check("delivery_cnt", 32'(n_obs), 32'(n_exp));
        exp_q.delete();
        @(posedge clk);
        for (int k = 0; k < 16; k++)
            if (m_valid[k] && ordy[k]) m_valid[k] = 1'b0;
        if (acc) begin
            m_data[dst]  = d;
            m_valid[dst] = 1'b1;
            if (md) m_ptr = (m_ptr + 1) % 16;
            m_count = (m_count + 1) % 65536;
        end
        #1;
    endtask

    initial begin
        logic [W-1:0] exp_lane0;

        apply_reset();

        // Explicit mode, lane k receives k
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 4'(i), W'(i), 1'b0, 16'hFFFF);
            check("x033_valid", 32'(bus.out_valid[i]), 1);
            check("x033_data", 32'(bus.out_data[i*W +: W]), 32'(i));
        end
        check("x033_count", 32'(bus.count), 16);
        check("x033_ptr", 32'(bus.ptr), 0);
        step(1'b0, 4'd0, '0, 1'b0, 16'hFFFF);

        // Stalled lane 5, then simultaneous drain and reload
        step(1'b1, 4'd5, 4'hA, 1'b0, 16'hFFDF);
        step(1'b1, 4'd5, 4'hB, 1'b0, 16'hFFDF);
        check("x034_stall_ready", 32'(last_rdy), 0);
        check("x034_hold_data", 32'(bus.out_data[5*W +: W]), 32'hA);
        step(1'b1, 4'd5, 4'hB, 1'b0, 16'hFFFF);
        check("x034_pass_ready", 32'(last_rdy), 1);
        check("x034_valid_kept", 32'(bus.out_valid[5]), 1);
        check("x034_new_data", 32'(bus.out_data[5*W +: W]), 32'hB);
        step(1'b0, 4'd0, '0, 1'b0, 16'hFFFF);

        // Sweep mode, 17 accepts
        apply_reset();
        exp_lane0 = '0;
        for (int i = 0; i < 17; i++) begin
            step(1'b1, 4'(15 - i), W'(i * 3 + 1), 1'b1, 16'hFFFF);
            check("x035_lane", 32'(bus.out_data[(i % 16)*W +: W]), 32'((i * 3 + 1) % 16));
            exp_lane0 = W'(i * 3 + 1);
        end
        check("x035_ptr", 32'(bus.ptr), 1);
        check("x035_count", 32'(bus.count), 17);
        check("x035_lane0", 32'(bus.out_data[0 +: W]), 32'(exp_lane0));

        // Lane 3 full and stalled, lane 7 keeps flowing
        step(1'b1, 4'd3, 4'h3, 1'b0, 16'hFFF7);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 4'd7, W'($urandom_range(0, 15)), 1'b0, 16'hFFF7);
            check("x036_lane7_ready", 32'(last_rdy), 1);
            check("x036_lane3_data", 32'(bus.out_data[3*W +: W]), 3);
            check("x036_lane3_valid", 32'(bus.out_valid[3]), 1);
        end

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), W'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)), 16'($urandom() | $urandom()));
        end

        // Counter wrap
        apply_reset();
        for (int i = 0; i < 65535; i++)
            step(1'b1, 4'd0, W'($urandom_range(0, 15)), 1'b1, 16'hFFFF);
        check("x037_count_max", 32'(bus.count), 32'hFFFF);
        step(1'b1, 4'd0, 4'h1, 1'b1, 16'hFFFF);
        check("x037_count_wrap", 32'(bus.count), 0);

        // Mid-operation reset with lanes 2 and 9 full
        step(1'b1, 4'd2, 4'h6, 1'b0, 16'hFDFB);
        step(1'b1, 4'd9, 4'h9, 1'b0, 16'hFDFB);
        check("x038_pre_valid", 32'(bus.out_valid), 32'h0204);
        rst_n = 1'b0;
        #1;
        check("x038_rst_valid", 32'(bus.out_valid), 0);
        check("x038_rst_ptr", 32'(bus.ptr), 0);
        check("x038_rst_count", 32'(bus.count), 0);
        bus.in_valid = 1'b1;
        bus.in_sel   = 4'd2;
        bus.mode     = 1'b0;
        #1;
        check("x038_rst_ready", 32'(bus.in_ready), 1);
        #3;
        rst_n = 1'b1;
        model_reset();
        step(1'b1, 4'd2, 4'hC, 1'b0, 16'hFDFB);
        check("x038_reload_valid", 32'(bus.out_valid), 32'h0004);
        check("x038_reload_data", 32'(bus.out_data[2*W +: W]), 32'hC);
        check("x038_reload_count", 32'(bus.count), 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/demux116.md
DEMUX116 -- requirements
Module: demux116

Interface
REQ-001 Parameter WIDTH, default 1, sets the data width of the input and of each output lane.
REQ-002 Parameter SWEEP_EN, default 1; when 0, mode is forced to explicit select regardless of the mode input.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 in_data  input  WIDTH  data word to route.
REQ-006 in_sel  input  4  destination lane in explicit mode; {s1,s2,s3,s4} order, with in_sel[3] as MSB.
REQ-007 in_valid  input  1  in_data/in_sel valid this cycle.
REQ-008 in_ready  output  1  block can accept this cycle.
REQ-009 mode  input  1  0 = explicit select via in_sel; 1 = sweep via internal pointer.
REQ-010 out_data  output  16*WIDTH  lane k occupies bits [k*WIDTH +: WIDTH].
REQ-011 out_valid  output  16  lane k holds an undelivered word.
REQ-012 out_ready  input  16  lane k consumer accepts this cycle.
REQ-013 ptr  output  4  current sweep pointer.
REQ-014 count  output  16  total accepted words, wrapping.

Function
REQ-015 Destination lane dst SHALL be in_sel when the effective mode is 0, and ptr when the effective mode is 1.
REQ-016 Each lane SHALL be a 1-deep holding register with its own valid bit.
REQ-017 in_ready SHALL equal ~out_valid[dst] | out_ready[dst], computed combinationally.
REQ-018 Accept SHALL occur when in_valid & in_ready; on accept, lane dst data <= in_data and out_valid[dst] <= 1 at the next edge.
REQ-019 At most one lane SHALL load per cycle, and no lane other than dst SHALL change data on accept.
REQ-020 Lane k delivery SHALL occur when out_valid[k] & out_ready[k]; out_valid[k] SHALL clear at the next edge unless lane k is reloaded in the same cycle.
REQ-021 Simultaneous delivery and accept on the same lane SHALL leave out_valid[k]=1 with the new data, giving full throughput of one word per cycle.
REQ-022 Deliveries on lanes other than dst SHALL proceed independently in the same cycle as an accept.
REQ-023 Latency SHALL be one cycle: a word accepted at edge N is visible on out_data/out_valid after edge N.
REQ-024 out_data of a lane with out_valid=0 SHALL hold its last value, which is don't-care to consumers.
REQ-025 ptr SHALL increment by 1 on each accept while the effective mode is 1, wrapping 15 -> 0, and SHALL hold otherwise.
REQ-026 A mode change SHALL take effect in the same cycle and SHALL NOT modify ptr.
REQ-027 count SHALL increment by 1 on each accept in either mode, wrapping 0xFFFF -> 0x0000.
REQ-028 in_valid=1 with in_ready=0 SHALL cause no state change; the source holds its word.
REQ-029 Lane valid bits and data SHALL change only per REQ-018 and REQ-020.

Reset
REQ-030 While rst_n=0: out_valid=0, out_data=0, ptr=0, count=0, and in_ready reflects the cleared lanes (1 whenever dst is empty).
REQ-031 Assertion of rst_n mid-operation SHALL immediately discard all held words without delivery.
REQ-032 After rst_n rises, the first accept is possible at the first rising clk edge.

Verification
REQ-033 Explicit mode, all out_ready=1, one word per cycle with in_sel 0..15 and in_data=in_sel (WIDTH=4) -> each lane k shows data k one cycle later; count=16; ptr=0.
REQ-034 Explicit mode, out_ready[5]=0, two words to lane 5 (0xA, then 0xB) -> first accepted, in_ready=0 on the second, lane 5 holds 0xA; raise out_ready[5] -> 0xA delivered and 0xB loaded in the same cycle, out_valid[5] stays 1.
REQ-035 Sweep mode, 17 accepts, all out_ready=1 -> lanes 0..15 then 0 loaded in order; ptr=1; count=17.
REQ-036 Lane 3 full and stalled while words target lane 7 -> lane 7 accepts every cycle, lane 3 unchanged.
REQ-037 count preloaded to 0xFFFF via 65535 accepts, then one more accept -> count=0x0000.
REQ-038 rst_n low for half a cycle with lanes 2 and 9 full -> out_valid=0 immediately and ptr=0; next accept to lane 2 succeeds at the first edge after release.
